bcd_count_up_2d: RTL
====================

// Module: bcd_count_up_2d
// PURPOSE
//  Two-digit BCD up-counter with enable, synchronous clear, parallel load and
//  programmable wrap value. Counterpart of the single-digit BCD down-counter.
//  Sits in lab timer/clock datapaths (e.g. seconds 00..59) and feeds the 7-seg
//  display mux. Terminal-count output cascades stages (sec -> min -> hour).
// PARAMETERS
//  MAX_TENS  5  tens digit of wrap value (0..9)
//  MAX_ONES  9  ones digit of wrap value (0..9); wrap value = MAX_TENS*10+MAX_ONES
// PORTS
//  clk       in   1  system clock, rising edge
//  reset     in   1  asynchronous reset, active-low
//  en        in   1  count enable; one increment per clk while high
//  clr       in   1  synchronous clear to 00
//  load      in   1  synchronous parallel load strobe
//  load_val  in   8  BCD load value {tens[7:4], ones[3:0]}
//  ones      out  4  BCD ones digit (registered)
//  tens      out  4  BCD tens digit (registered)
//  tc        out  1  terminal count, combinational: en & count==wrap & ~clr & ~load
//  wrap      out  1  registered 1-cycle pulse after a wrap wrap->00
//  load_err  out  1  registered 1-cycle pulse after a rejected load
// BEHAVIOUR
//  - Reset (reset==0, async): ones=0, tens=0, wrap=0, load_err=0. Held while low.
//  - Priority per rising edge: clr > load > en > hold.
//  - clr: count<=00; wrap, load_err <=0 that cycle.
//  - load: accepted iff load_val[7:4]<=9, load_val[3:0]<=9, and value<=wrap value.
//    Accepted -> count<=load_val, load_err<=0. Rejected -> count holds, load_err<=1.
//  - en, count!=wrap value: ones<=ones+1; if ones==9 then ones<=0, tens<=tens+1.
//  - en, count==wrap value: count<=00, wrap<=1 (high exactly one cycle).
//  - wrap and load_err are 0 in every cycle not described above.
//  - Increment latency: 1 clk (new count visible after the enabling edge).
//  - tc is purely combinational, same cycle as the wrapping edge; drives next
//    stage en. No combinational path from load_val to any output.
//  - Out-of-range state (not reachable normally): with en, treated as != wrap;
//    ones>9 -> ones<=0 with tens increment; tens>9 -> tens<=0. Recovers <=16 clk.
//  - Arithmetic: 4-bit per digit, no binary carry past 9; never outputs A..F
//    from a legal state.
//  - Reset asserted mid-count: immediate async clear; first edge after release
//    acts on inputs normally.
//  - en low: count, tc=0; pulses return to 0 next edge.
// TESTING
//  1 reset low, en=1 -> ones=0,tens=0; release, 12 clks -> 12 (BCD 8'h12).
//  2 load 8'h58, en=1 -> 59 (tc=1 that cycle), next edge 00 with wrap=1 one cycle.
//  3 load 8'h3A, then 8'h61 (MAX=59) -> count holds, load_err=1 one cycle each.
//  4 clr=1,load=1,en=1 same edge from 8'h27 -> 00; load=1,en=1 -> load_val wins.
//  5 en toggled 1/0 over 200 clks -> count = (#enabled edges) mod 60, BCD legal.
//  6 assert reset mid-count at 8'h44 between edges -> outputs 0 without clk edge.

Source files
------------

// File: rtl/bcd_count_up_2d.sv
// Two-digit BCD up-counter with clear, checked parallel load and a
// programmable wrap value; tc cascades into the next stage's enable.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous reset, active low
//   en        count enable, one step per clock
//   clr       synchronous clear to 00 (highest priority)
//   load      synchronous load strobe (below clr, above en)
//   load_val  BCD load value {tens, ones}
//   ones      registered BCD ones digit
//   tens      registered BCD tens digit
//   tc        combinational terminal count for cascading
//   wrap      one-cycle pulse after a wrap to 00
//   load_err  one-cycle pulse after a rejected load

module bcd_count_up_2d #(
    parameter int unsigned MAX_TENS = 5,
    parameter int unsigned MAX_ONES = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       tc,
    output logic       wrap,
    output logic       load_err
);

    localparam logic [3:0] LP_MAX_T = 4'(MAX_TENS);
    localparam logic [3:0] LP_MAX_O = 4'(MAX_ONES);
    localparam logic [3:0] LP_NINE  = 4'd9;

    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic       r_wrap;
    logic       r_load_err;

    logic       w_at_max;
    logic       w_load_ok;
    logic [3:0] w_lv_t;
    logic [3:0] w_lv_o;
    logic [3:0] w_inc_ones;
    logic [3:0] w_inc_tens;

    assign w_lv_t = load_val[7:4];
    assign w_lv_o = load_val[3:0];

    // Out-of-range states can never equal the (legal) wrap value,
    // so they always take the increment path and recover.
    assign w_at_max = (r_tens == LP_MAX_T) && (r_ones == LP_MAX_O);

    assign w_load_ok = (w_lv_t <= LP_NINE) && (w_lv_o <= LP_NINE) &&
                       ((w_lv_t < LP_MAX_T) ||
                        ((w_lv_t == LP_MAX_T) && (w_lv_o <= LP_MAX_O)));

    // Digit-wise increment; ones >= 9 covers both the decade carry
    // and illegal A..F ones values.
    always_comb begin
        w_inc_ones = r_ones + 4'd1;
        w_inc_tens = r_tens;
        if (r_ones >= LP_NINE) begin
            w_inc_ones = 4'd0;
            w_inc_tens = (r_tens >= LP_NINE) ? 4'd0 : r_tens + 4'd1;
        end
        if (r_tens > LP_NINE) begin
            w_inc_tens = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ones     <= 4'd0;
            r_tens     <= 4'd0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
            if (clr) begin
                r_ones <= 4'd0;
                r_tens <= 4'd0;
            end else if (load) begin
                if (w_load_ok) begin
                    r_ones <= w_lv_o;
                    r_tens <= w_lv_t;
                end else begin
                    r_load_err <= 1'b1;
                end
            end else if (en) begin
                if (w_at_max) begin
                    r_ones <= 4'd0;
                    r_tens <= 4'd0;
                    r_wrap <= 1'b1;
                end else begin
                    r_ones <= w_inc_ones;
                    r_tens <= w_inc_tens;
                end
            end
        end
    end

    assign tc       = en & w_at_max & ~clr & ~load;
    assign ones     = r_ones;
    assign tens     = r_tens;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;

endmodule
